// File: rtl/dtack_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtack_gen_pkg
// Brief    : Shared state encoding and default slot timing for dtack_gen.
// Revision : 1.0
// ============================================================================
package dtack_gen_pkg;

    // Responder state encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COUNT   = 2'd1;
    localparam logic [1:0] c_ST_EXTWAIT = 2'd2;
    localparam logic [1:0] c_ST_ACK     = 2'd3;

    // Default board map: slot0=0, slot1=2, slot2=5, slot3=1 wait states
    localparam int         c_DEF_NSLOTS         = 4;
    localparam int         c_DEF_WS_WIDTH       = 4;
    localparam logic [15:0] c_DEF_WAIT_STATES   = {4'd1, 4'd5, 4'd2, 4'd0};
    localparam logic [3:0] c_DEF_EXT_READY_MASK = 4'b1000;

    // Width of a slot index; a single-slot build still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtack_gen_slot_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : slot_prio_enc
// Brief    : Lowest-index-wins priority encoder for the chip-select vector.
// Revision : 1.0
// ============================================================================
module slot_prio_enc #(
    parameter int NSLOTS = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NSLOTS-1:0] sel,
    output logic [IDX_W-1:0]  index,
    output logic              any
);

    // Scan downwards so the lowest set bit is the last to write the index
    always_comb begin
        index = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (sel[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign any = |sel;

endmodule
`default_nettype wire

// File: rtl/dtack_gen.sv
`default_nettype none
// ============================================================================
// Module   : dtack_gen
// Brief    : 68000 responder DTACK generator with per-slot wait states and
//            optional external-ready handshake.
// Revision : 1.0
// ============================================================================
module dtack_gen
    import dtack_gen_pkg::*;
#(
    parameter int                         NSLOTS         = c_DEF_NSLOTS,
    parameter int                         WS_WIDTH       = c_DEF_WS_WIDTH,
    parameter logic [NSLOTS*WS_WIDTH-1:0] WAIT_STATES    = c_DEF_WAIT_STATES,
    parameter logic [NSLOTS-1:0]          EXT_READY_MASK = c_DEF_EXT_READY_MASK,
    localparam int                        IDX_W          = idx_width(NSLOTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              as_active,
    input  logic [NSLOTS-1:0] sel,
    input  logic [NSLOTS-1:0] ext_ready,
    output logic              dtack,
    output logic              busy,
    output logic [IDX_W-1:0]  active_slot
);

    logic [1:0]          r_state;
    logic [WS_WIDTH-1:0] r_count;
    logic [IDX_W-1:0]    r_slot;
    logic                r_dtack;
    logic                r_busy;

    logic [1:0]          w_state_nxt;
    logic [WS_WIDTH-1:0] w_count_nxt;
    logic [IDX_W-1:0]    w_slot_nxt;

    logic                w_any;
    logic [IDX_W-1:0]    w_idx;
    logic [WS_WIDTH-1:0] w_ws_tbl [NSLOTS];
    logic [WS_WIDTH-1:0] w_ws_new;
    logic                w_mask_new;
    logic                w_mask_cur;
    logic                w_ready_cur;

    slot_prio_enc #(
        .NSLOTS (NSLOTS),
        .IDX_W  (IDX_W)
    ) u_prio (
        .sel   (sel),
        .index (w_idx),
        .any   (w_any)
    );

    generate
        for (genvar g = 0; g < NSLOTS; g++) begin : g_ws
            assign w_ws_tbl[g] = WAIT_STATES[g*WS_WIDTH +: WS_WIDTH];
        end
    endgenerate

    assign w_ws_new    = w_ws_tbl[w_idx];
    assign w_mask_new  = EXT_READY_MASK[w_idx];
    assign w_mask_cur  = EXT_READY_MASK[r_slot];
    assign w_ready_cur = ext_ready[r_slot];

    // A dropped strobe outside IDLE always wins, so an aborted cycle never acks
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_slot_nxt  = r_slot;
        case (r_state)
            c_ST_IDLE: begin
                if (as_active && w_any) begin
                    w_slot_nxt  = w_idx;
                    w_count_nxt = w_ws_new;
                    if (w_ws_new != '0) begin
                        w_state_nxt = c_ST_COUNT;
                    end else if (w_mask_new) begin
                        w_state_nxt = c_ST_EXTWAIT;
                    end else begin
                        w_state_nxt = c_ST_ACK;
                    end
                end
            end
            c_ST_COUNT: begin
                if (!as_active) begin
                    w_state_nxt = c_ST_IDLE;
                    w_count_nxt = '0;
                    w_slot_nxt  = '0;
                end else begin
                    w_count_nxt = r_count - WS_WIDTH'(1);
                    if (r_count == WS_WIDTH'(1)) begin
                        w_state_nxt = w_mask_cur ? c_ST_EXTWAIT : c_ST_ACK;
                    end
                end
            end
            c_ST_EXTWAIT: begin
                if (!as_active) begin
                    w_state_nxt = c_ST_IDLE;
                    w_slot_nxt  = '0;
                end else if (w_ready_cur) begin
                    w_state_nxt = c_ST_ACK;
                end
            end
            c_ST_ACK: begin
                if (!as_active) begin
                    w_state_nxt = c_ST_IDLE;
                    w_slot_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_count_nxt = '0;
                w_slot_nxt  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so dtack/busy are glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
            r_slot  <= '0;
            r_dtack <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_slot  <= w_slot_nxt;
            r_dtack <= (w_state_nxt == c_ST_ACK);
            r_busy  <= (w_state_nxt != c_ST_IDLE);
        end
    end

    assign dtack       = r_dtack;
    assign busy        = r_busy;
    assign active_slot = r_slot;

endmodule
`default_nettype wire

// File: tb/tb_dtack_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtack_gen
// Brief    : Scoreboard bench for dtack_gen with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_dtack_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       as_active;
    logic [3:0] sel;
    logic [3:0] ext_ready;
    logic       dtack;
    logic       busy;
    logic [1:0] active_slot;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int rise;
        int fall;
        int slot;
    } exp_t;

    exp_t sb[$];
    int   ws_tab[4]   = '{0, 2, 5, 1};
    bit   mask_tab[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic prev_dtack  = 1'b0;

    dtack_gen u_dut (
        .clk         (clk),
        .reset       (reset),
        .as_active   (as_active),
        .sel         (sel),
        .ext_ready   (ext_ready),
        .dtack       (dtack),
        .busy        (busy),
        .active_slot (active_slot)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: each dtack rise/fall is matched against the oldest expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (dtack && !prev_dtack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dtack_rise: got dtack=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    check("dtack_rise_cycle", cyc, sb[0].rise);
                    check("ack_active_slot", int'(active_slot), sb[0].slot);
                    check("busy_during_ack", int'(busy), 1);
                end
            end
            if (!dtack && prev_dtack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dtack_fall: got fall with no pending cycle (cycle %0d)", cyc);
                end else begin
                    check("dtack_fall_cycle", cyc, sb[0].fall);
                    void'(sb.pop_front());
                end
            end
        end
        prev_dtack <= reset ? 1'b0 : dtack;
    end

    // One strobe: held for len edges, ext_ready of a masked slot high from edge E0+d.
    // Called right after a falling edge; E0 is the next rising edge.
    task automatic run_txn(input logic [3:0] s, input int len, input int d, input int gap);
        int   e0;
        int   slot;
        int   ack;
        exp_t x;
        e0   = cyc + 1;
        slot = -1;
        for (int i = 0; i < 4; i++) begin
            if (s[i] && slot < 0) slot = i;
        end
        if (slot >= 0) begin
            if (mask_tab[slot]) ack = (e0 + ws_tab[slot] + 1 > e0 + d) ? e0 + ws_tab[slot] + 1 : e0 + d;
            else                ack = e0 + ws_tab[slot];
            if (ack <= e0 + len - 1) begin
                x.rise = ack;
                x.fall = e0 + len;
                x.slot = slot;
                sb.push_back(x);
            end
        end
        as_active = 1'b1;
        sel       = s;
        for (int k = 0; k < len; k++) begin
            if (k > 0 && s != 4'd0) sel = 4'($urandom);
            ext_ready = 4'($urandom);
            if (slot >= 0 && mask_tab[slot]) ext_ready[slot] = (k >= d);
            @(negedge clk);
            if (s == 4'd0) check("nosel_busy_low", int'(busy), 0);
        end
        as_active = 1'b0;
        sel       = 4'($urandom);
        ext_ready = 4'($urandom);
        @(negedge clk);
        check("idle_busy_after_strobe", int'(busy), 0);
        check("idle_dtack_after_strobe", int'(dtack), 0);
        check("idle_slot_after_strobe", int'(active_slot), 0);
        repeat (gap - 1) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        as_active = 1'b0;
        sel       = 4'd0;
        ext_ready = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_dtack", int'(dtack), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_slot", int'(active_slot), 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a slot1 wait
        as_active = 1'b1;
        sel       = 4'b0010;
        @(negedge clk);
        check("midcycle_busy", int'(busy), 1);
        check("midcycle_slot", int'(active_slot), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_dtack", int'(dtack), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_slot", int'(active_slot), 0);
        @(negedge clk);
        as_active = 1'b0;
        sel       = 4'd0;
        reset     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_idle", int'(busy), 0);
        end

        run_txn(4'b0001, 6, 0, 1);    // WS=0
        run_txn(4'b0110, 8, 0, 2);    // priority picks slot1
        run_txn(4'b0100, 10, 0, 2);   // slot2, WS=5
        run_txn(4'b1000, 30, 22, 2);  // slot3 stalls on ext_ready
        run_txn(4'b1000, 8, 0, 1);    // slot3 with ready already high
        run_txn(4'b0100, 3, 0, 2);    // abort before ack
        run_txn(4'b0000, 70, 0, 2);   // no select
        run_txn(4'b0001, 11, 0, 1);   // strobe held long, one-cycle gap
        run_txn(4'b0001, 4, 0, 2);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run_txn(s, $urandom_range(1, 30), $urandom_range(0, 25), $urandom_range(1, 3));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dtack_gen.md
Name: dtack_gen

Overview:
- Responder-side companion to the bus timer, on the same 68000 bus.
- Watches address strobe and per-device chip selects.
- Inserts a per-slot programmable number of wait states, optionally waits for a slow device's ready, then asserts DTACK until the strobe negates.
- An unselected or stalled cycle never gets DTACK; the bus timer then raises the timeout that leads to /BERR.

Parameters:
- NSLOTS, 4, number of chip-select slots.
- WS_WIDTH, 4, width of each wait-state count.
- WAIT_STATES, {4'd1,4'd5,4'd2,4'd0}, packed NSLOTS*WS_WIDTH vector; slot i in bits [i*WS_WIDTH +: WS_WIDTH].
- EXT_READY_MASK, 4'b1000, slot i set = after its wait states, also wait for ext_ready[i].

Ports:
- clk  in  1  CPU clock.
- reset  in  1  asynchronous, active-high reset.
- as_active  in  1  address strobe asserted (active-high, already synchronized to clk).
- sel  in  NSLOTS  decoded chip selects, active-high.
- ext_ready  in  NSLOTS  per-slot device ready, active-high.
- dtack  out  1  registered DTACK, active-high; board logic inverts it to /DTACK.
- busy  out  1  a cycle is in progress (state != IDLE).
- active_slot  out  $clog2(NSLOTS)  latched slot index; valid while busy, 0 otherwise.

Behaviour:
- Reset (async, any state): state=IDLE, dtack=0, busy=0, active_slot=0, count=0.
- States: IDLE, COUNT, EXTWAIT, ACK. dtack=1 only in ACK. All outputs are registered.
- IDLE:
  - At edge E0 with as_active=1 and sel!=0: latch the lowest-index set sel bit as slot, and load count=WAIT_STATES[slot].
  - Next state: COUNT if count>0; else EXTWAIT if mask[slot]; else ACK.
  - as_active=1 with sel==0: stay IDLE, dtack stays 0.
- COUNT: decrement count each edge. On the edge where count==1 (reaching 0), go to EXTWAIT if mask[slot], else ACK.
- Latency, unmasked slot: dtack first high at edge E0+WS+1. WS=0 gives dtack at E0+1.
- EXTWAIT: go to ACK on the first edge sampling ext_ready[slot]=1. There is no timeout here; the bus timer covers a stall.
  - ext_ready already high: masked-slot dtack at E0+WS+2 (or E0+2 if WS=0).
- ACK: hold dtack=1 while as_active=1. On the edge sampling as_active=0: dtack=0, go to IDLE.
- New cycles are recognized only from IDLE, so back-to-back strobes need at least one sample of as_active=0 between them. A strobe held high after ACK never re-triggers.
- Abort: as_active=0 sampled in COUNT or EXTWAIT: go to IDLE, dtack never asserts. This covers a cycle terminated by bus error.
- sel and WAIT_STATES slot choice are latched at E0. Later sel changes are ignored until IDLE.
- Multiple sel bits set: the lowest index wins. No error is flagged.
- ext_ready of non-active slots is ignored.
- Count arithmetic is unsigned WS_WIDTH; maximum is 2^WS_WIDTH-1 wait states. No wrap, because the counter is loaded and only decremented while >0.

Decomposition:
- Package dtack_gen_pkg: state encoding (IDLE/COUNT/EXTWAIT/ACK) as localparams, plus default wait-state constants.
- One sub-module, slot_prio_enc: combinational lowest-index-set priority encoder. Inputs sel[NSLOTS]; outputs index and any.
- The FSM and counter stay in dtack_gen.

Test Plan:
All scenarios use default parameters.
- Reset mid-cycle: slot1 in COUNT, assert reset -> dtack=0, busy=0, active_slot=0 immediately. After release with as_active=0, stays IDLE.
- Slot0 (WS=0): as_active=1, sel=4'b0001 at E0 -> dtack=1 at E0+1, held while as_active=1. dtack=0 on the edge sampling as_active=0; busy then 0.
- Slot2 (WS=5) and priority: sel=4'b0110 at E0 -> active_slot=1, dtack at E0+3 (slot1 WS=2). Repeat with sel=4'b0100 -> dtack at E0+6.
- Slot3 ext wait: sel=4'b1000, ext_ready[3]=0 -> no dtack through E0+20. Raise ext_ready[3] -> dtack one edge after it is sampled. Toggling ext_ready[2] has no effect.
- Abort and no-select:
  - Slot2 cycle, drop as_active at E0+3 -> dtack never asserts, IDLE at E0+4.
  - as_active=1 with sel=0 for 70 clocks -> dtack stays 0, busy stays 0.
- Back-to-back: as_active held high after ACK for 10 clocks -> single dtack pulse. A one-cycle as_active=0 gap, then a new strobe with sel=4'b0001 -> new dtack at E0'+1.
